// File: rtl/synth_dds_pkg.sv
// Shared widths, helpers and types for the synth DDS voice path.
// Optional feature macro: PHASE_HARD_SYNC_EN (voice-0 hard sync).
package synth_dds_pkg;

    localparam int DDS_ACC_W  = 24;
    localparam int DDS_FTW_W  = 16;
    localparam int DDS_ADDR_W = 8;

    typedef logic [DDS_ACC_W-1:0] phase_t;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dds_phase_lane.sv
// One DDS voice: phase register, gate edge detect, wrap pulse.
// Optional feature macro: PHASE_HARD_SYNC_EN (drives sync_in).
module dds_phase_lane #(
    parameter int FTW_W = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk_10k,
    input  logic             rst,
    input  logic             en,
    input  logic             gate,
    input  logic [FTW_W-1:0] ftw,
    input  logic             sync_in,
    output logic [ACC_W-1:0] acc,
    output logic             wrap,
    output logic             active,
    output logic             carry
);

    logic             gate_q;
    logic             rise;
    logic [ACC_W:0]   sum;

    always_comb begin
        rise  = gate & ~gate_q;
        sum   = {1'b0, acc} + (ACC_W+1)'(ftw);
        // Carry as it would be registered this cycle; feeds hard sync.
        carry = en & gate & ~rise & sum[ACC_W];
    end

    always_ff @(posedge clk_10k) begin
        if (rst) begin
            acc    <= '0;
            gate_q <= 1'b0;
            wrap   <= 1'b0;
        end else if (en) begin
            gate_q <= gate;
            if (rise) begin
                acc  <= '0;
                wrap <= 1'b0;
            end else if (gate && sync_in) begin
                acc  <= '0;
                wrap <= 1'b0;
            end else if (gate) begin
                acc  <= sum[ACC_W-1:0];
                wrap <= sum[ACC_W];
            end else begin
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    assign active = gate_q;

endmodule

// File: rtl/poly_phase_accumulator.sv
// Multi-voice DDS phase accumulator with per-voice tuning words.
// Optional feature macro: PHASE_HARD_SYNC_EN adds sync_mask hard sync.
module poly_phase_accumulator
    import synth_dds_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int FTW_W  = DDS_FTW_W,
    parameter int ACC_W  = DDS_ACC_W,
    parameter int ADDR_W = DDS_ADDR_W
) (
    input  logic                     clk_10k,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     ftw_we,
    input  logic [ch_w(NUM_CH)-1:0]  ftw_sel,
    input  logic [FTW_W-1:0]         ftw_in,
    input  logic [NUM_CH-1:0]        gate,
`ifdef PHASE_HARD_SYNC_EN
    input  logic [NUM_CH-1:0]        sync_mask,
`endif
    output logic [NUM_CH*ADDR_W-1:0] address,
    output logic [NUM_CH-1:0]        wrap,
    output logic [NUM_CH-1:0]        active
);

    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0] lane_carry;
    logic [NUM_CH-1:0] sync_in;

`ifdef PHASE_HARD_SYNC_EN
    logic unused_mask0;
    assign unused_mask0 = sync_mask[0];

    // Voice 0 is the sync master and never resyncs itself.
    always_comb begin
        sync_in = '0;
        for (int c = 1; c < NUM_CH; c++)
            sync_in[c] = sync_mask[c] & lane_carry[0];
    end
`else
    logic unused_carry;
    assign unused_carry = ^lane_carry;
    assign sync_in      = '0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        localparam logic [CH_W-1:0] SEL = CH_W'(c);

        logic [FTW_W-1:0] ftw_q;
        logic [ACC_W-1:0] acc;

        // Unmatched select codes simply hit no voice.
        always_ff @(posedge clk_10k) begin
            if (rst)
                ftw_q <= '0;
            else if (ftw_we && ftw_sel == SEL)
                ftw_q <= ftw_in;
        end

        dds_phase_lane #(
            .FTW_W (FTW_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk_10k (clk_10k),
            .rst     (rst),
            .en      (en),
            .gate    (gate[c]),
            .ftw     (ftw_q),
            .sync_in (sync_in[c]),
            .acc     (acc),
            .wrap    (wrap[c]),
            .active  (active[c]),
            .carry   (lane_carry[c])
        );

        assign address[c*ADDR_W +: ADDR_W] = acc[ACC_W-1 -: ADDR_W];
    end

endmodule

// File: tb/tb_poly_phase_accumulator.sv
// Directed bench for poly_phase_accumulator (default and hard-sync builds).
module tb_poly_phase_accumulator;

    logic        clk_10k = 1'b0;
    logic        rst;
    logic        en;
    logic        ftw_we;
    logic [1:0]  ftw_sel;
    logic [15:0] ftw_in;
    logic [3:0]  gate;
    logic [31:0] address;
    logic [3:0]  wrap;
    logic [3:0]  active;
`ifdef PHASE_HARD_SYNC_EN
    logic [3:0]  sync_mask;
`endif

    logic        ftw_we5;
    logic [2:0]  ftw_sel5;
    logic [15:0] ftw_in5;
    logic [4:0]  gate5;
    logic [39:0] address5;
    logic [4:0]  wrap5;
    logic [4:0]  active5;

    int errors = 0;
    int checks = 0;
    int nz;

    always #5 clk_10k = ~clk_10k;

    poly_phase_accumulator u_dut (
        .clk_10k   (clk_10k),
        .rst       (rst),
        .en        (en),
        .ftw_we    (ftw_we),
        .ftw_sel   (ftw_sel),
        .ftw_in    (ftw_in),
        .gate      (gate),
`ifdef PHASE_HARD_SYNC_EN
        .sync_mask (sync_mask),
`endif
        .address   (address),
        .wrap      (wrap),
        .active    (active)
    );

    poly_phase_accumulator #(.NUM_CH(5)) u_dut5 (
        .clk_10k   (clk_10k),
        .rst       (rst),
        .en        (en),
        .ftw_we    (ftw_we5),
        .ftw_sel   (ftw_sel5),
        .ftw_in    (ftw_in5),
        .gate      (gate5),
`ifdef PHASE_HARD_SYNC_EN
        .sync_mask (5'b0),
`endif
        .address   (address5),
        .wrap      (wrap5),
        .active    (active5)
    );

    task automatic step();
        @(posedge clk_10k);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ftw_we = 1'b0; ftw_sel = '0; ftw_in = '0;
        gate = '0;
        ftw_we5 = 1'b0; ftw_sel5 = '0; ftw_in5 = '0; gate5 = '0;
`ifdef PHASE_HARD_SYNC_EN
        sync_mask = 4'b0010;
`endif
        step(); step();
        chk("rst_addr", address, 32'h0);
        chk("rst_wrap", {28'h0, wrap}, 32'h0);
        chk("rst_active", {28'h0, active}, 32'h0);
        rst = 1'b0;
        nz = 0;
        repeat (20) begin
            step();
            if (address != 32'h0) nz++;
        end
        chk("idle_addr_20cyc", nz, 0);

        // Basic accumulate on voice 0
        ftw_we = 1'b1; ftw_sel = 2'd0; ftw_in = 16'h0100;
        step();
        ftw_we = 1'b0; gate = 4'b0001;
        step();
        chk("v0_rise_acc", u_dut.g_lane[0].acc, 32'h0);
        chk("v0_active", {28'h0, active}, 32'h1);
        step();
        chk("v0_acc1", u_dut.g_lane[0].acc, 32'h000100);
        repeat (254) step();
        chk("v0_acc255", u_dut.g_lane[0].acc, 32'h00FF00);
        chk("v0_addr255", address[7:0], 32'h0);
        step();
        chk("v0_addr256", address[7:0], 32'h01);
        chk("v0_nowrap", wrap[0], 1'b0);
        gate = 4'b0000;
        step();

        // Wrap and restart on voice 1
        ftw_we = 1'b1; ftw_sel = 2'd1; ftw_in = 16'hFFFF;
        step();
        ftw_we = 1'b0; gate = 4'b0010;
        step();
        chk("v1_rise_acc", u_dut.g_lane[1].acc, 32'h0);
        nz = 0;
        repeat (256) begin
            step();
            if (wrap[1]) nz++;
        end
        chk("v1_no_early_wrap", nz, 0);
        chk("v1_acc256", u_dut.g_lane[1].acc, 32'hFFFF00);
        step();
        chk("v1_wrap257", wrap[1], 1'b1);
        chk("v1_acc257", u_dut.g_lane[1].acc, 32'h00FEFF);
        step();
        chk("v1_wrap_pulse", wrap[1], 1'b0);
        chk("v1_acc258", u_dut.g_lane[1].acc, 32'h01FEFE);
        gate = 4'b0000;
        step();
        chk("v1_hold1", u_dut.g_lane[1].acc, 32'h01FEFE);
        chk("v1_inactive", active[1], 1'b0);
        step(); step();
        chk("v1_hold3", u_dut.g_lane[1].acc, 32'h01FEFE);
        gate = 4'b0010;
        step();
        chk("v1_restart", u_dut.g_lane[1].acc, 32'h0);
        chk("v1_reactive", active[1], 1'b1);

        // Write corner cases
        ftw_we = 1'b1; ftw_sel = 2'd2; ftw_in = 16'h1234; gate = 4'b0110;
        step();
        chk("v2_rise_with_write", u_dut.g_lane[2].acc, 32'h0);
        ftw_we = 1'b0;
        step();
        chk("v2_new_ftw", u_dut.g_lane[2].acc, 32'h001234);

        gate5 = 5'h1F; ftw_we5 = 1'b1; ftw_sel5 = 3'd5; ftw_in5 = 16'h1234;
        step();
        ftw_sel5 = 3'd7;
        step();
        ftw_we5 = 1'b0;
        step();
        chk("n5_sel5_l0", u_dut5.g_lane[0].acc, 32'h0);
        chk("n5_sel5_l1", u_dut5.g_lane[1].acc, 32'h0);
        chk("n5_sel5_l2", u_dut5.g_lane[2].acc, 32'h0);
        chk("n5_sel5_l3", u_dut5.g_lane[3].acc, 32'h0);
        chk("n5_sel5_l4", u_dut5.g_lane[4].acc, 32'h0);
        ftw_we5 = 1'b1; ftw_sel5 = 3'd4; ftw_in5 = 16'h0010;
        step();
        ftw_we5 = 1'b0;
        step();
        chk("n5_sel4_l4", u_dut5.g_lane[4].acc, 32'h000010);
        chk("n5_sel4_l3", u_dut5.g_lane[3].acc, 32'h0);

        // Enable gating on voice 3
        ftw_we = 1'b1; ftw_sel = 2'd3; ftw_in = 16'h8000;
        step();
        ftw_we = 1'b0; gate = 4'b1110;
        step();
        chk("v3_rise", u_dut.g_lane[3].acc, 32'h0);
        step();
        chk("en1_acc", u_dut.g_lane[3].acc, 32'h008000);
        en = 1'b0;
        step();
        chk("en0_hold_a", u_dut.g_lane[3].acc, 32'h008000);
        chk("en0_wrap_a", {28'h0, wrap}, 32'h0);
        ftw_we = 1'b1; ftw_sel = 2'd3; ftw_in = 16'h4000;
        step();
        ftw_we = 1'b0;
        chk("en0_hold_b", u_dut.g_lane[3].acc, 32'h008000);
        chk("en0_wrap_b", {28'h0, wrap}, 32'h0);
        en = 1'b1;
        step();
        chk("en1_new_ftw", u_dut.g_lane[3].acc, 32'h00C000);

        // Reset mid-note clears phase and tuning words
        rst = 1'b1;
        step();
        chk("midrst_acc3", u_dut.g_lane[3].acc, 32'h0);
        chk("midrst_active", {28'h0, active}, 32'h0);
        rst = 1'b0;
        step(); step();
        chk("midrst_ftw_cleared", u_dut.g_lane[3].acc, 32'h0);

        // Voice-0 hard sync onto voice 1; voice 2 unmasked
        gate = 4'b0000;
        step();
        ftw_we = 1'b1; ftw_sel = 2'd0; ftw_in = 16'hFFFF;
        step();
        ftw_sel = 2'd1; ftw_in = 16'h0001;
        step();
        ftw_sel = 2'd2;
        step();
        ftw_we = 1'b0; gate = 4'b0111;
        step();
        repeat (256) step();
        chk("sync_pre_v1", u_dut.g_lane[1].acc, 32'd256);
        chk("sync_pre_v0wrap", wrap[0], 1'b0);
        step();
        chk("sync_v0wrap", wrap[0], 1'b1);
`ifdef PHASE_HARD_SYNC_EN
        chk("sync_v1_zero", u_dut.g_lane[1].acc, 32'd0);
`else
        chk("nosync_v1_free", u_dut.g_lane[1].acc, 32'd257);
`endif
        chk("sync_v1_wrap", wrap[1], 1'b0);
        chk("sync_v2_free", u_dut.g_lane[2].acc, 32'd257);
        step();
`ifdef PHASE_HARD_SYNC_EN
        chk("sync_v1_next", u_dut.g_lane[1].acc, 32'd1);
`else
        chk("nosync_v1_next", u_dut.g_lane[1].acc, 32'd258);
`endif
        chk("sync_v2_next", u_dut.g_lane[2].acc, 32'd258);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
